// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the frequency meter and its capture front end.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE,
        DONE
    } state_e;

    localparam int DEF_NUM_PERIODS = 4;
    localparam int DEF_LOG2_NP     = $clog2(DEF_NUM_PERIODS);

    // Accumulator width that can hold np full-scale periods without overflow.
    function automatic int sum_width(input int w, input int np);
        return w + $clog2(np);
    endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Input synchronizer plus edge register; level/rise/fall are mutually aligned and
// arrive SYNC_STAGES+1 cycles after the raw input moves.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            level_q <= sync_q[SYNC_STAGES-1];
            rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/freq_meter.sv
// One-shot period / high-time meter: averages NUM_PERIODS rise-to-rise intervals of
// SigIn in Clk cycles and reports the high time of the last interval.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_PERIODS = DEF_NUM_PERIODS,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Start,
    input  logic [WIDTH-1:0] TimeoutCfg,
    input  logic             SigIn,
    output logic             Busy,
    output logic             Done,
    output logic             Timeout,
    output logic [WIDTH-1:0] PeriodOut,
    output logic [WIDTH-1:0] HighOut
);

    localparam int LOG2_NP = $clog2(NUM_PERIODS);
    localparam int SUM_W   = sum_width(WIDTH, NUM_PERIODS);
    localparam int IDX_W   = (LOG2_NP > 0) ? LOG2_NP : 1;

    logic level, rise_p, fall_p;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .sig_i  (SigIn),
        .level_o(level),
        .rise_o (rise_p),
        .fall_o (fall_p)
    );

    state_e             state_q;
    logic [WIDTH-1:0]   cnt_q, hcnt_q, hlast_q, tcfg_q;
    logic [SUM_W-1:0]   sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q, done_q, tmo_q;
    logic [WIDTH-1:0]   period_q, high_q;

    logic [WIDTH-1:0]   cnt_inc_d, hcnt_inc_d, period_d;
    logic [SUM_W-1:0]   sum_fin_d;
    logic               tmo_hit_d, last_per_d;

    assign cnt_inc_d  = (cnt_q  == '1) ? cnt_q  : cnt_q  + WIDTH'(1);
    assign hcnt_inc_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + WIDTH'(1);
    assign sum_fin_d  = sum_q + SUM_W'(cnt_q);
    assign period_d   = WIDTH'(sum_fin_d >> LOG2_NP);
    assign last_per_d = (idx_q == IDX_W'(NUM_PERIODS - 1));
    // A rise in the matching cycle wins; callers test rise_p before this.
    assign tmo_hit_d  = (tcfg_q != '0) && (cnt_q == tcfg_q);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            hlast_q  <= '0;
            tcfg_q   <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
        end else if (!Enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= WAIT_FIRST;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        hcnt_q  <= '0;
                        hlast_q <= '0;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        tcfg_q  <= TimeoutCfg;
                    end
                end
                WAIT_FIRST: begin
                    if (rise_p) begin
                        state_q <= MEASURE;
                        cnt_q   <= WIDTH'(1);
                        hcnt_q  <= WIDTH'(1);
                    end else if (tmo_hit_d) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        tmo_q    <= 1'b1;
                        period_q <= '0;
                        high_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                MEASURE: begin
                    if (rise_p) begin
                        if (last_per_d) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            period_q <= period_d;
                            high_q   <= hlast_q;
                        end else begin
                            sum_q <= sum_fin_d;
                            idx_q <= idx_q + IDX_W'(1);
                            cnt_q <= WIDTH'(1);
                            hcnt_q <= WIDTH'(1);
                        end
                    end else if (tmo_hit_d) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        tmo_q    <= 1'b1;
                        period_q <= '0;
                        high_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        if (level)  hcnt_q  <= hcnt_inc_d;
                        if (fall_p) hlast_q <= hcnt_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Timeout   = tmo_q;
    assign PeriodOut = period_q;
    assign HighOut   = high_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: stimulus pushes expected results, a monitor checks
// every Done/Timeout pulse against the queue.
module tb_freq_meter;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Enable = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] TimeoutCfg = '0;
    logic         SigIn = 1'b0;
    logic         Busy, Done, Timeout;
    logic [W-1:0] PeriodOut, HighOut;

    freq_meter #(.WIDTH(W), .NUM_PERIODS(4), .SYNC_STAGES(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .Start     (Start),
        .TimeoutCfg(TimeoutCfg),
        .SigIn     (SigIn),
        .Busy      (Busy),
        .Done      (Done),
        .Timeout   (Timeout),
        .PeriodOut (PeriodOut),
        .HighOut   (HighOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit           is_tmo;
        logic [W-1:0] per;
        logic [W-1:0] high;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   hi_t[4];
    int   lo_t[4];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done || Timeout) begin
            exp_t e;
            chk("done_and_timeout_exclusive", W'(Done & Timeout), '0);
            chk("busy_low_on_result", W'(Busy), '0);
            if (q.size() == 0) begin
                chk("unexpected_result_pulse", W'(1), '0);
            end else begin
                e = q.pop_front();
                chk("result_kind_timeout", W'(Timeout), W'(e.is_tmo));
                chk("period_out", PeriodOut, e.per);
                chk("high_out", HighOut, e.high);
            end
        end
    end

    task automatic wait_not_busy(input string nm, input int budget);
        int n = 0;
        while (Busy && n < budget) begin
            tick(1);
            n++;
        end
        if (Busy) chk({nm, "_busy_timeout"}, W'(Busy), '0);
    endtask

    // Drives hi_t/lo_t as four periods plus a closing rise; restart re-pulses Start mid-run.
    task automatic measure(input string nm, input bit restart, input int ep, input int eh);
        exp_t e;
        e.is_tmo = 1'b0; e.per = W'(ep); e.high = W'(eh);
        q.push_back(e);
        Start = 1'b1; tick(1); Start = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            SigIn = 1'b1;
            if (restart && i == 1) begin
                Start = 1'b1; tick(1); Start = 1'b0; tick(hi_t[i] - 1);
            end else begin
                tick(hi_t[i]);
            end
            SigIn = 1'b0; tick(lo_t[i]);
        end
        SigIn = 1'b1;
        wait_not_busy(nm, 30);
        tick(2);
        SigIn = 1'b0;
        tick(8);
        chk({nm, "_result_consumed"}, W'(q.size()), '0);
    endtask

    initial begin
        int n;
        exp_t e;
        tick(3);
        chk("reset_busy", W'(Busy), '0);
        chk("reset_done", W'(Done), '0);
        chk("reset_timeout", W'(Timeout), '0);
        chk("reset_period", PeriodOut, '0);
        chk("reset_high", HighOut, '0);
        Reset = 1'b1; Enable = 1'b1;
        tick(4);

        hi_t = '{5, 5, 5, 5}; lo_t = '{5, 5, 5, 5};
        measure("sq_5_5", 1'b0, 10, 5);
        hi_t = '{3, 3, 3, 3}; lo_t = '{7, 7, 7, 7};
        measure("duty_3_7", 1'b0, 10, 3);
        hi_t = '{4, 4, 5, 6}; lo_t = '{4, 5, 5, 5};
        measure("per_8_to_11", 1'b0, 9, 6);

        // Enable drop after two periods: abort quietly, keep previous results.
        Start = 1'b1; tick(1); Start = 1'b0; tick(3);
        for (int i = 0; i < 2; i++) begin
            SigIn = 1'b1; tick(5); SigIn = 1'b0; tick(5);
        end
        SigIn = 1'b1; tick(4);
        chk("abort_busy_before", W'(Busy), W'(1));
        Enable = 1'b0; tick(1);
        chk("abort_busy", W'(Busy), '0);
        chk("abort_period_kept", PeriodOut, W'(9));
        chk("abort_high_kept", HighOut, W'(6));
        Enable = 1'b1; SigIn = 1'b0; tick(6);
        chk("abort_stays_idle", W'(Busy), '0);

        // Enable low overrides Start.
        Enable = 1'b0; Start = 1'b1; tick(1); Start = 1'b0; Enable = 1'b1;
        chk("start_en0_busy", W'(Busy), '0);
        tick(3);
        chk("start_en0_idle", W'(Busy), '0);

        // DC low with a 100-cycle timeout.
        TimeoutCfg = W'(100);
        e.is_tmo = 1'b1; e.per = '0; e.high = '0;
        q.push_back(e);
        Start = 1'b1; tick(1); Start = 1'b0;
        TimeoutCfg = '0;
        n = 0;
        while (Busy && n < 500) begin
            n++;
            tick(1);
        end
        chk("timeout_busy_cycles", W'(n), W'(101));
        tick(3);
        chk("timeout_consumed", W'(q.size()), '0);

        // Start re-pulsed while busy must not restart the measurement.
        hi_t = '{6, 6, 6, 6}; lo_t = '{6, 6, 6, 6};
        measure("restart_ignored", 1'b1, 12, 6);

        // Reset mid-measurement clears everything.
        Start = 1'b1; tick(1); Start = 1'b0; tick(3);
        SigIn = 1'b1; tick(4); SigIn = 1'b0; tick(4); SigIn = 1'b1; tick(4);
        Reset = 1'b0; tick(1);
        chk("midrst_busy", W'(Busy), '0);
        chk("midrst_done", W'(Done), '0);
        chk("midrst_timeout", W'(Timeout), '0);
        chk("midrst_period", PeriodOut, '0);
        chk("midrst_high", HighOut, '0);
        Reset = 1'b1; SigIn = 1'b0; tick(6);

        hi_t = '{3, 3, 3, 3}; lo_t = '{3, 3, 3, 3};
        measure("fresh_per_6", 1'b0, 6, 3);

        chk("queue_empty_at_end", W'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
